// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_000C;
  localparam int          WORD_BYTES         = 4;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush kills it, otherwise hold.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  import fetch_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus4 <= d_pc + 32'(WORD_BYTES);
    end else if (flush) begin
      // payload is left as-is; only the valid bit matters downstream
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC priority mux, RUN/HALT/FAULT FSM and delivered-instruction counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = 6,
  parameter logic [31:0] HALT_INSTR = fetch_pkg::HALT_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fetch_count
);
  import fetch_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         load, flush;
  logic         out_of_range;

  assign imem_a       = pc[IMEM_AW+1:2];
  assign out_of_range = |pc[31:IMEM_AW+2];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      RUN: begin
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
          state_nxt = FAULT;
          flush     = 1'b1;
        end else if (redirect) begin
          pc_nxt = redirect_pc;
          flush  = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (out_of_range) begin
          state_nxt = FAULT;
          flush     = 1'b1;
        end else if (imem_rd == HALT_INSTR) begin
          // deliver the halt word but keep pc pointing at it
          load      = 1'b1;
          state_nxt = HALT;
        end else begin
          load   = 1'b1;
          pc_nxt = pc + 32'(WORD_BYTES);
        end
      end
      HALT:    flush = !stall;
      FAULT:   flush = 1'b1;
      default: state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      halted <= (state_nxt == HALT);
      fault  <= (state_nxt == FAULT);
      if (load && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .flush    (flush),
    .d_instr  (imem_rd),
    .d_pc     (pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .pc_plus4 (id_pc_plus4)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 64-word imem.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic        id_valid, halted, fault;
  logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

  logic [31:0] mem [64];
  int n_chk  = 0;
  int n_fail = 0;

  assign imem_rd = mem[imem_a];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_AW    (6),
    .HALT_INSTR (32'h0000_000C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .halted      (halted),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_instr"}, id_instr, 32'd0);
    chk({tag, "_pc"},    id_pc, 32'd0);
    chk({tag, "_pc4"},   id_pc_plus4, 32'd0);
    chk({tag, "_halt"},  32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_cnt"},   fetch_count, 32'd0);
    chk({tag, "_ia"},    32'(imem_a), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0000_0000; mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222; mem[3] = 32'h3333_3333;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // 1: sequential fetch
    do_reset();
    chk_reset_vals("rst");
    for (int k = 0; k < 4; k++) begin
      chk("seq_ia", 32'(imem_a), 32'(k));
      tick();
      chk("seq_instr", id_instr, {4{4'(k), 4'(k)}});
      chk("seq_pc",    id_pc, 32'(4 * k));
      chk("seq_pc4",   id_pc_plus4, 32'(4 * k + 4));
      chk("seq_valid", 32'(id_valid), 32'd1);
    end
    chk("seq_cnt", fetch_count, 32'd4);

    // 2: stall while id_pc=4
    do_reset();
    tick(2);
    chk("st_pre_pc", id_pc, 32'h4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_instr", id_instr, 32'h1111_1111);
      chk("st_ia",    32'(imem_a), 32'd2);
    end
    chk("st_cnt", fetch_count, 32'd2);
    stall = 1'b0;
    tick();
    chk("st_resume", id_instr, 32'h2222_2222);

    // 3: redirect beats stall
    redirect = 1'b1; redirect_pc = 32'h0000_000C; stall = 1'b1;
    tick();
    chk("rd_valid", 32'(id_valid), 32'd0);
    chk("rd_ia",    32'(imem_a), 32'd3);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("rd_instr", id_instr, 32'h3333_3333);
    chk("rd_pc",    id_pc, 32'h0000_000C);
    chk("rd_valid2", 32'(id_valid), 32'd1);

    // 4: halt
    mem[2] = 32'h0000_000C;
    do_reset();
    tick(3);
    chk("h_instr", id_instr, 32'h0000_000C);
    chk("h_valid", 32'(id_valid), 32'd1);
    chk("h_halt0", 32'(halted), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0020;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("h_ia", 32'(imem_a), 32'd2);
    end
    chk("h_valid2", 32'(id_valid), 32'd0);
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_cnt",    fetch_count, 32'd3);
    redirect = 1'b0;

    // 6a: reset out of HALT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rh");
    mem[2] = 32'h2222_2222;
    tick();
    chk("rh_refetch", id_instr, 32'h0000_0000);
    chk("rh_valid",   32'(id_valid), 32'd1);

    // 5a: misaligned redirect
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    chk("f_fault", 32'(fault), 32'd1);
    chk("f_valid", 32'(id_valid), 32'd0);
    redirect_pc = 32'h0000_0010; stall = 1'b1;
    tick(3);
    chk("f_ia_frozen", 32'(imem_a), 32'd2);
    chk("f_fault2",    32'(fault), 32'd1);
    redirect = 1'b0; stall = 1'b0;

    // 6b: reset out of FAULT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rf");

    // 5b: run off the end of imem
    tick(64);
    chk("e_pc",    id_pc, 32'h0000_00FC);
    chk("e_fault0", 32'(fault), 32'd0);
    chk("e_cnt",   fetch_count, 32'd64);
    tick();
    chk("e_fault", 32'(fault), 32'd1);
    chk("e_valid", 32'(id_valid), 32'd0);
    chk("e_ia",    32'(imem_a), 32'd0);
    chk("e_cnt2",  fetch_count, 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
